btn_bounce_gen: RTL

Synthesizable bouncy-push-button emulator for the TapTempo chip: the transmitting end of the debouncer's button input.
- On a start request it drives a press/hold/release sequence on btn_o, with pseudo-random contact bounce on both edges.
- Timed in tp_i time-pulse units, the same timebase the debouncer uses.
- Used for on-chip self-test (btn_o muxed into the debouncer input) and as a deterministic stimulus source in simulation.

---
 rtl/btn_bounce_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/btn_bounce_gen.sv
// Bouncy push-button emulator: on a start request it plays a press, hold and release
// sequence on btn_o, with LFSR-timed contact bounce, counted in tp_i time pulses.
module btn_bounce_gen #(
    parameter int          PULSE_PER_NS  = 5120,
    parameter int          BOUNCE_CNT    = 3,
    parameter int          HOLD_TP       = 64,
    parameter int          MAX_GLITCH_TP = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tp_i,
    input  logic start_i,
    output logic btn_o,
    output logic busy_o,
    output logic done_o
);

    localparam int EW = $clog2(2 * BOUNCE_CNT + 2);
    localparam int SW = $clog2(MAX_GLITCH_TP + 1);
    localparam int HW = $clog2(HOLD_TP + 1);

    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * BOUNCE_CNT + 1);
    localparam logic [SW-1:0] SEG_MASK  = SW'(MAX_GLITCH_TP - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TP);
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    if (PULSE_PER_NS < 1 || BOUNCE_CNT < 0 || HOLD_TP < 1 || MAX_GLITCH_TP < 1 ||
        (MAX_GLITCH_TP & (MAX_GLITCH_TP - 1)) != 0 || LFSR_SEED == 16'h0000) begin : g_bad_param
        $error("btn_bounce_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        s_idle,
        s_press,
        s_hold,
        s_release
    } state_t;

    state_t          state, state_nx;
    logic [EW-1:0]   edge_cnt, edge_nx;
    logic [SW-1:0]   seg_cnt, seg_nx;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic [15:0]     lfsr, lfsr_nx;
    logic            btn_nx;
    logic            done_nx;

    logic [SW-1:0]   seg_len;
    logic [15:0]     lfsr_step;

    // Segment length is drawn from the LFSR value present at the load, before any advance
    assign seg_len   = (lfsr[SW-1:0] & SEG_MASK) + SW'(1);
    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign busy_o    = (state != s_idle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= s_idle;
            btn_o    <= 1'b0;
            done_o   <= 1'b0;
            edge_cnt <= '0;
            seg_cnt  <= '0;
            hold_cnt <= '0;
            lfsr     <= LFSR_SEED;
        end else begin
            state    <= state_nx;
            btn_o    <= btn_nx;
            done_o   <= done_nx;
            edge_cnt <= edge_nx;
            seg_cnt  <= seg_nx;
            hold_cnt <= hold_nx;
            lfsr     <= lfsr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        btn_nx   = btn_o;
        done_nx  = 1'b0;
        edge_nx  = edge_cnt;
        seg_nx   = seg_cnt;
        hold_nx  = hold_cnt;
        lfsr_nx  = lfsr;

        case (state)
            s_idle: begin
                // The done_o cycle still counts as the tail of the previous sequence
                if (start_i && !done_o) begin
                    state_nx = s_press;
                    btn_nx   = 1'b1;
                    edge_nx  = EW'(1);
                    seg_nx   = seg_len;
                end
            end

            s_press, s_release: begin
                if (tp_i) begin
                    lfsr_nx = lfsr_step;
                    if (seg_cnt > SW'(1)) begin
                        seg_nx = seg_cnt - SW'(1);
                    end else if (edge_cnt < LAST_EDGE) begin
                        btn_nx  = ~btn_o;
                        edge_nx = edge_cnt + EW'(1);
                        seg_nx  = seg_len;
                    end else if (state == s_press) begin
                        state_nx = s_hold;
                        hold_nx  = HOLD_LOAD;
                        edge_nx  = '0;
                        seg_nx   = '0;
                    end else begin
                        state_nx = s_idle;
                        done_nx  = 1'b1;
                        edge_nx  = '0;
                        seg_nx   = '0;
                    end
                end
            end

            s_hold: begin
                if (tp_i) begin
                    if (hold_cnt > HW'(1)) begin
                        hold_nx = hold_cnt - HW'(1);
                    end else begin
                        state_nx = s_release;
                        hold_nx  = '0;
                        btn_nx   = 1'b0;
                        edge_nx  = EW'(1);
                        seg_nx   = seg_len;
                    end
                end
            end

            default: state_nx = s_idle;
        endcase
    end

endmodule
